// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR3 parity sequencer: state encoding and
// the width helper used to size the step counter.
package xnor_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r++;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xnor3_step.sv
// Single XNOR3 datapath cell: folds the running parity with two data bits.
module xnor3_step (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f
);

    assign f = ~(a ^ b ^ c);

endmodule

// File: rtl/xnor_parity_ctrl.sv
// Parity sequencer: folds a WIDTH-bit word two bits per clock through one
// XNOR3 cell, then checks the result against a supplied parity bit.
module xnor_parity_ctrl
    import xnor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_odd,
    input  logic             in_chk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam int STEPS  = WIDTH / 2;
    localparam int STEP_W = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    // Each XNOR step adds one inversion; seeding with STEPS parity cancels them.
    localparam logic ACC_SEED = 1'(STEPS % 2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic              acc_q, acc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              odd_q, odd_d;
    logic              chk_q, chk_d;
    logic              par_q, par_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_f;

    xnor3_step u_step (
        .a (acc_q),
        .b (sh_q[0]),
        .c (sh_q[1]),
        .f (step_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
            ST_SHIFT: if (step_q == LAST_STEP) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_d   = sh_q;
        acc_d  = acc_q;
        step_d = step_q;
        odd_d  = odd_q;
        chk_d  = chk_q;
        par_d  = par_q;
        err_d  = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d   = in_data;
                    odd_d  = in_odd;
                    chk_d  = in_chk;
                    acc_d  = ACC_SEED;
                    step_d = '0;
                end
            end
            ST_SHIFT: begin
                acc_d  = step_f;
                sh_d   = sh_q >> 2;
                step_d = step_q + STEP_W'(1);
                // Final fold result goes straight into the held output registers.
                if (step_q == LAST_STEP) begin
                    par_d = step_f ^ odd_q;
                    err_d = step_f ^ odd_q ^ chk_q;
                end
            end
            default: ;
        endcase
    end

    // Clear wins over a same-cycle error increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (state_q == ST_DONE && out_ready && err_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            acc_q  <= 1'b0;
            step_q <= '0;
            odd_q  <= 1'b0;
            chk_q  <= 1'b0;
            par_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            step_q <= step_d;
            odd_q  <= odd_d;
            chk_q  <= chk_d;
            par_q  <= par_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_parity = par_q;
    assign out_err    = err_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_xnor_parity_ctrl.sv
// Scoreboard bench for xnor_parity_ctrl (WIDTH=8, STEPS=4).
module tb_xnor_parity_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_odd;
    logic             in_chk;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    typedef struct packed {
        logic par;
        logic err;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               passed = 0;
    int               cycle  = 0;
    logic [CNT_W-1:0] cnt_model;

    xnor_parity_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_odd     (in_odd),
        .in_chk     (in_chk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_err    (out_err),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c, input logic err,
                                                  input logic clr);
        if (clr) return '0;
        if (err && c != {CNT_W{1'b1}}) return c + 1'b1;
        return c;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '{par: 1'bx, err: 1'bx};
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] d, input logic o, input logic c, output int acc_cyc);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_data  = d;
        in_odd   = o;
        in_chk   = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cycle;
        in_valid = 1'b0;
        in_data  = ~d;
        in_odd   = ~o;
        in_chk   = ~c;
        sb_q.push_back('{par: (^d) ^ o, err: (^d) ^ o ^ c});
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take(input logic clr, output logic p, output logic e);
        p         = out_parity;
        e         = out_err;
        out_ready = 1'b1;
        err_clr   = clr;
        @(posedge clk); #1;
        out_ready = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic run_word(input logic [WIDTH-1:0] d, input logic o, input logic c, input logic clr,
                            output int acc_cyc, output int lat, output logic p, output logic e,
                            output exp_t ex);
        send(d, o, c, acc_cyc);
        wait_out(lat);
        ex = pop_exp();
        take(clr, p, e);
        cnt_model = next_cnt(cnt_model, ex.err, clr);
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_parity !== 1'b0) $display("FAIL reset_out_parity: got %b want 0", out_parity); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", out_err); else passed++;
        checks++; if (err_cnt !== '0) $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); else passed++;
        rst = 1'b0;
        cnt_model = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] td[4];
        logic             to[4];
        logic             tc[4];
        int a, lat;
        logic p, e;
        exp_t ex;
        td = '{8'hA5, 8'h01, 8'h01, 8'hFF};
        to = '{1'b0, 1'b0, 1'b1, 1'b1};
        tc = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_word(td[i], to[i], tc[i], 1'b0, a, lat, p, e, ex);
            checks++; if (lat !== 4) $display("FAIL basic%0d_latency: got %0d want 4", i, lat); else passed++;
            checks++; if (p !== ex.par) $display("FAIL basic%0d_parity: got %b want %b", i, p, ex.par); else passed++;
            checks++; if (e !== ex.err) $display("FAIL basic%0d_err: got %b want %b", i, e, ex.err); else passed++;
            checks++; if (err_cnt !== cnt_model) $display("FAIL basic%0d_err_cnt: got %0h want %0h", i, err_cnt, cnt_model); else passed++;
        end
    endtask

    task automatic test_stall();
        int a, lat;
        logic p, e;
        exp_t ex;
        send(8'h07, 1'b0, 1'b0, a);
        wait_out(lat);
        ex = pop_exp();
        in_valid = 1'b1;
        in_data  = 8'hF0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL stall%0d_out_valid: got %b want 1", i, out_valid); else passed++;
            checks++; if (out_parity !== ex.par) $display("FAIL stall%0d_parity: got %b want %b", i, out_parity, ex.par); else passed++;
            checks++; if (out_err !== ex.err) $display("FAIL stall%0d_err: got %b want %b", i, out_err, ex.err); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL stall%0d_in_ready: got %b want 0", i, in_ready); else passed++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take(1'b0, p, e);
        cnt_model = next_cnt(cnt_model, ex.err, 1'b0);
        checks++; if (err_cnt !== cnt_model) $display("FAIL stall_err_cnt: got %0h want %0h", err_cnt, cnt_model); else passed++;
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) $display("FAIL stall_ignored_word: out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_back_idle: in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_saturate();
        int a, lat;
        logic p, e;
        exp_t ex;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        cnt_model = '0;
        checks++; if (err_cnt !== cnt_model) $display("FAIL sat_clear: got %0h want %0h", err_cnt, cnt_model); else passed++;
        for (int i = 0; i < 255; i++) run_word(8'h01, 1'b0, 1'b0, 1'b0, a, lat, p, e, ex);
        checks++; if (err_cnt !== cnt_model) $display("FAIL sat_preload: got %0h want %0h", err_cnt, cnt_model); else passed++;
        run_word(8'h01, 1'b0, 1'b0, 1'b0, a, lat, p, e, ex);
        checks++; if (err_cnt !== cnt_model) $display("FAIL sat_hold: got %0h want %0h", err_cnt, cnt_model); else passed++;
        run_word(8'h01, 1'b0, 1'b0, 1'b1, a, lat, p, e, ex);
        checks++; if (err_cnt !== cnt_model) $display("FAIL sat_clr_priority: got %0h want %0h", err_cnt, cnt_model); else passed++;
    endtask

    task automatic test_reset_mid();
        int a, lat;
        logic p, e;
        exp_t ex;
        send(8'hFF, 1'b0, 1'b1, a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        cnt_model = '0;
        checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (err_cnt !== cnt_model) $display("FAIL midrst_err_cnt: got %0h want %0h", err_cnt, cnt_model); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_word(8'h03, 1'b0, 1'b0, 1'b0, a, lat, p, e, ex);
        checks++; if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat); else passed++;
        checks++; if (p !== ex.par) $display("FAIL midrst_parity: got %b want %b", p, ex.par); else passed++;
        checks++; if (e !== ex.err) $display("FAIL midrst_err: got %b want %b", e, ex.err); else passed++;
    endtask

    task automatic test_back_to_back();
        int a, prev_a, lat;
        logic p, e;
        exp_t ex;
        logic [WIDTH-1:0] d;
        prev_a = 0;
        for (int i = 0; i < 8; i++) begin
            d = WIDTH'($urandom);
            run_word(d, 1'($urandom), 1'($urandom), 1'b0, a, lat, p, e, ex);
            checks++; if (p !== ex.par) $display("FAIL b2b%0d_parity: got %b want %b (data %0h)", i, p, ex.par, d); else passed++;
            checks++; if (e !== ex.err) $display("FAIL b2b%0d_err: got %b want %b", i, e, ex.err); else passed++;
            if (i > 0) begin
                checks++; if (a - prev_a !== 6) $display("FAIL b2b%0d_throughput: got %0d want 6", i, a - prev_a); else passed++;
            end
            prev_a = a;
        end
        checks++; if (err_cnt !== cnt_model) $display("FAIL b2b_err_cnt: got %0h want %0h", err_cnt, cnt_model); else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_odd    = 1'b0;
        in_chk    = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
